// File: rtl/sp_ram_arb2.sv
// sp_ram_arb2: round-robin burst arbiter and address sequencer that lets two
// requesters share one single-port, 1-cycle-latency, no-change block RAM.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   mN_req/we/addr/blen    burst request and parameters (N = 0, 1)
//   mN_wdata, mN_ack       per-beat write data, beat accepted (combinational)
//   mN_rvalid, mN_rdata    read return, registered valid, data from ram_dout
//   ram_en/we/addr/di      RAM drive
//   ram_dout               RAM read data
module sp_ram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int BLEN_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [BLEN_WIDTH-1:0] m0_blen,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [BLEN_WIDTH-1:0] m1_blen,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BLEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rtag_v_q, rtag_v_d;
    logic                  rtag_p_q, rtag_p_d;

    logic own_req;
    logic beat;
    logic gnt;

    assign own_req = owner_q ? m1_req : m0_req;
    assign beat    = (state_q == S_BURST) & own_req;

    // A tie goes to whoever was not served last; otherwise the sole requester.
    assign gnt = (m0_req & m1_req) ? ~last_q : m1_req;

    assign ram_en   = beat;
    assign ram_we   = beat & we_q;
    assign ram_addr = addr_q;
    assign ram_di   = owner_q ? m1_wdata : m0_wdata;

    assign m0_ack = beat & ~owner_q;
    assign m1_ack = beat & owner_q;

    assign m0_rvalid = rtag_v_q & ~rtag_p_q;
    assign m1_rvalid = rtag_v_q & rtag_p_q;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rtag_v_d = beat & ~we_q;
        rtag_p_d = owner_q;
        unique case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = S_BURST;
                    owner_d = gnt;
                    we_d    = gnt ? m1_we : m0_we;
                    addr_d  = gnt ? m1_addr : m0_addr;
                    cnt_d   = gnt ? m1_blen : m0_blen;
                end
            end
            S_BURST: begin
                if (beat) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        last_d  = owner_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rtag_v_q <= 1'b0;
            rtag_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rtag_v_q <= rtag_v_d;
            rtag_p_q <= rtag_p_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_arb2.sv
// tb_sp_ram_arb2: scoreboard bench for sp_ram_arb2 with a behavioural RAM,
// directed scenarios and two randomized masters.
module tb_sp_ram_arb2;

    typedef struct {
        bit          we;
        logic [9:0]  addr;
        logic [15:0] data;
        bit          last;
    } beat_t;

    typedef struct {
        int          p;
        logic [15:0] d;
        int          cyc;
    } rd_t;

    logic        clk;
    logic        resetn;
    logic        mreq [2];
    logic        mwe [2];
    logic [9:0]  maddr [2];
    logic [3:0]  mblen [2];
    logic [15:0] mwd [2];
    logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_di, ram_dout;

    logic [15:0] mem [1024];
    logic [15:0] refm [1024];

    beat_t bq0 [$];
    beat_t bq1 [$];
    rd_t   rdq [$];

    int n_checks = 0;
    int n_fail   = 0;

    sp_ram_arb2 #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .BLEN_WIDTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_req    (mreq[0]),
        .m0_we     (mwe[0]),
        .m0_addr   (maddr[0]),
        .m0_blen   (mblen[0]),
        .m0_wdata  (mwd[0]),
        .m0_ack    (m0_ack),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (mreq[1]),
        .m1_we     (mwe[1]),
        .m1_addr   (maddr[1]),
        .m1_blen   (mblen[1]),
        .m1_wdata  (mwd[1]),
        .m1_ack    (m1_ack),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // No-change single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the last ack.
    task automatic burst(input int p, input bit we, input logic [9:0] a,
                         input logic [3:0] bl, input int st_at,
                         input int st_len);
        logic [15:0] d [$];
        int i;
        int to;
        bit stalled;
        for (int k = 0; k <= int'(bl); k++) begin
            beat_t b;
            b.we   = we;
            b.addr = a + 10'(k);
            b.data = 16'($urandom);
            b.last = (k == int'(bl));
            d.push_back(b.data);
            if (p == 0) bq0.push_back(b);
            else        bq1.push_back(b);
        end
        mwe[p]   = we;
        maddr[p] = a;
        mblen[p] = bl;
        mwd[p]   = d[0];
        mreq[p]  = 1'b1;
        i = 0;
        to = 0;
        stalled = 0;
        while (i <= int'(bl)) begin
            #1;
            if ((p == 0) ? m0_ack : m1_ack) i++;
            @(negedge clk);
            if (!stalled && st_len > 0 && i == st_at && i <= int'(bl)) begin
                stalled = 1;
                mreq[p] = 1'b0;
                repeat (st_len) @(negedge clk);
                mreq[p] = 1'b1;
            end
            if (i <= int'(bl)) mwd[p] = d[i];
            to++;
            if (to > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout port%0d: got %0d beats required %0d",
                         p, i, int'(bl) + 1);
                break;
            end
        end
        mreq[p] = 1'b0;
    endtask

    task automatic rand_master(input int p, input int n);
        for (int j = 0; j < n; j++) begin
            int gap;
            int sat;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            sat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 99;
            burst(p, 1'($urandom), 10'($urandom), 4'($urandom), sat,
                  int'($urandom_range(1, 3)));
        end
    endtask

    // Monitor: transaction-level model of the arbiter, checked every cycle.
    bit    free = 1;
    int    mlast = 1;
    int    own = 0;
    int    cyc = 0;
    beat_t mb;
    rd_t   mr;
    logic  a0, a1, ao, ax;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!resetn) begin
                chk("rst_ram_en", ram_en, 0);
                chk("rst_ack", {m0_ack, m1_ack}, 0);
                chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
                bq0.delete();
                bq1.delete();
                rdq.delete();
                free = 1;
                mlast = 1;
            end else begin
                a0 = m0_ack;
                a1 = m1_ack;
                if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
                    mr = rdq.pop_front();
                    chk("rvalid0", m0_rvalid, mr.p == 0);
                    chk("rvalid1", m1_rvalid, mr.p == 1);
                    chk("rdata", (mr.p == 0) ? m0_rdata : m1_rdata, mr.d);
                end else begin
                    chk("no_rvalid", {m0_rvalid, m1_rvalid}, 0);
                end
                chk("ram_en", ram_en, a0 | a1);
                if (free) begin
                    chk("idle_beat", {a0, a1}, 0);
                    if (mreq[0] || mreq[1]) begin
                        if (mreq[0] && mreq[1]) own = 1 - mlast;
                        else                    own = mreq[1] ? 1 : 0;
                        free = 0;
                    end
                end else begin
                    ao = (own == 1) ? a1 : a0;
                    ax = (own == 1) ? a0 : a1;
                    chk("owner_ack", ao, mreq[own]);
                    chk("other_ack", ax, 0);
                    if (ao) begin
                        if ((own == 0 && bq0.size() == 0) ||
                            (own == 1 && bq1.size() == 0)) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL extra_beat port%0d: got ack required none",
                                     own);
                        end else begin
                            if (own == 0) mb = bq0.pop_front();
                            else          mb = bq1.pop_front();
                            chk("ram_addr", ram_addr, mb.addr);
                            chk("ram_we", ram_we, mb.we);
                            if (mb.we) begin
                                chk("ram_di", ram_di, mb.data);
                                refm[mb.addr] = mb.data;
                            end else begin
                                rdq.push_back('{own, refm[mb.addr], cyc + 1});
                            end
                            if (mb.last) begin
                                free = 1;
                                mlast = own;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int k = 0; k < 1024; k++) begin
            mem[k]  = '0;
            refm[k] = '0;
        end
        ram_dout = '0;
        resetn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mreq[p]  = 1'b0;
            mwe[p]   = 1'b0;
            maddr[p] = '0;
            mblen[p] = '0;
            mwd[p]   = '0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        burst(0, 1, 10'h010, 4'd3, 99, 0);
        burst(0, 0, 10'h010, 4'd3, 99, 0);
        @(negedge clk);

        fork
            begin
                burst(0, 1, 10'h100, 4'd1, 99, 0);
                burst(0, 1, 10'h108, 4'd1, 99, 0);
            end
            burst(1, 1, 10'h200, 4'd1, 99, 0);
        join
        @(negedge clk);

        burst(0, 1, 10'h3FE, 4'd3, 99, 0);
        burst(1, 0, 10'h3FE, 4'd3, 99, 0);
        @(negedge clk);

        fork
            burst(1, 0, 10'h010, 4'd2, 1, 3);
            begin
                @(negedge clk);
                burst(0, 1, 10'h020, 4'd2, 99, 0);
            end
        join
        @(negedge clk);

        burst(0, 1, 10'h080, 4'd15, 99, 0);
        burst(1, 0, 10'h080, 4'd15, 99, 0);
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.we   = 0;
            b.addr = 10'h080 + 10'(k);
            b.data = '0;
            b.last = (k == 7);
            bq0.push_back(b);
        end
        mwe[0]   = 1'b0;
        maddr[0] = 10'h080;
        mblen[0] = 4'd7;
        mreq[0]  = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            #1;
            if (m0_ack) got = 1;
            else @(negedge clk);
        end
        chk("rst_first_ack", got, 1);
        @(posedge clk);
        #1;
        resetn  = 1'b0;
        mreq[0] = 1'b0;
        @(negedge clk);
        #3;
        chk("abort_rvalid", m0_rvalid, 0);
        chk("abort_ram_en", ram_en, 0);
        @(negedge clk);
        resetn = 1'b1;
        fork
            burst(0, 1, 10'h300, 4'd0, 99, 0);
            burst(1, 1, 10'h301, 4'd0, 99, 0);
        join
        @(negedge clk);

        fork
            rand_master(0, 25);
            rand_master(1, 25);
        join
        repeat (4) @(negedge clk);
        #3;
        chk("bq0_drained", bq0.size(), 0);
        chk("bq1_drained", bq1.size(), 0);
        chk("rdq_drained", rdq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_arb2.md
# sp_ram_arb2

Two-requester burst arbiter and sequencer for a single-port no-change block RAM (1-cycle read latency, `en`/`we`/`addr`/`di`/`dout` interface). It sits between two masters, e.g. the write-combining fill path and the PSRAM drain path of the Wishbone-to-PSRAM bridge, and a shared data buffer. The block grants whole bursts round-robin, generates incrementing RAM addresses, and routes read data back to the owning requester.

## Interface
- `ADDR_WIDTH`, 10, RAM address width; depth 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16, RAM word width.
- `BLEN_WIDTH`, 4, burst length field width; burst = blen+1 beats (1..2**BLEN_WIDTH).
- `clk` in 1: single clock; all logic on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `mN_req` in 1 (N=0,1): burst request / per-beat willingness; held high for the whole burst.
- `mN_we` in 1: 1 = write burst, 0 = read burst; sampled at grant.
- `mN_addr` in ADDR_WIDTH: burst base address; sampled at grant.
- `mN_blen` in BLEN_WIDTH: beats-1; sampled at grant.
- `mN_wdata` in DATA_WIDTH: write data for the current beat; consumed when `mN_ack`=1.
- `mN_ack` out 1: beat accepted this cycle (combinational).
- `mN_rvalid` out 1: read data valid (registered).
- `mN_rdata` out DATA_WIDTH: read data, wired from `ram_dout`; meaningful only with `mN_rvalid`.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_WIDTH, `ram_di` out DATA_WIDTH: RAM port drive.
- `ram_dout` in DATA_WIDTH: RAM read data, 1 cycle after `ram_en & ~ram_we`.

## Operation
- States: IDLE, BURST. Registers: `owner`, `last` (last granted port), `we_q`, `addr_q`, `cnt_q` (BLEN_WIDTH), `rtag_q` (valid + port).
- IDLE: if no `req`, stay. If one `req`, grant it. If both, grant `~last`. Grant latches owner, `mN_we`, `mN_addr`, `mN_blen` into `we_q`/`addr_q`/`cnt_q`; next state BURST. No beat is issued in IDLE.
- BURST: beat issued when `m[owner]_req`=1: `ram_en`=1, `ram_we`=`we_q`, `ram_addr`=`addr_q`, `ram_di`=`m[owner]_wdata`, `m[owner]_ack`=1. On a beat, `addr_q` increments modulo 2**ADDR_WIDTH (wraps from all-ones to 0) and `cnt_q` decrements.
- Owner `req` low in BURST: stall, no beat, no state change; the burst cannot be abandoned except by reset.
- Beat with `cnt_q`=0 is last: next state IDLE, `last`<=owner.
- Read beat sets `rtag_q`<={1,owner} for next cycle; `m[tag]_rvalid`=1 that cycle; other port rvalid 0.
- Non-owner `ack` and `rvalid` are always 0; non-owner `req` is ignored until IDLE.
- `ram_en`=0 in IDLE and on stall cycles; `ram_we`, `ram_addr`, `ram_di` are don't-care when `ram_en`=0.

## Timing
- Reset (`resetn` low, any time, asynchronous): state IDLE, `last`=1 (port 0 wins the first tie), `rtag_q` invalid. Outputs: `ram_en`=0, `mN_ack`=0, `mN_rvalid`=0. `ram_we`=0, `ram_addr`=0 and `ram_di` are don't-care. `mN_rdata` follows `ram_dout`, unqualified.
- Reset mid-burst aborts the burst. A pending rvalid is dropped and no further beats occur.
- Grant latency: `req` high in IDLE at cycle T gives the first beat at T+1 if `req` is still high.
- Back-to-back: last beat at T, IDLE at T+1 (arbitration), next burst's first beat at T+2. Minimum gap is one idle cycle.
- Read latency: beat at T gives `rvalid` and `rdata` at T+1, so a fully streamed read burst gives consecutive rvalids.
- Write data must be valid in the cycle `ack`=1, with no skid.
- Throughput: 1 beat/cycle within a burst when `req` is held.

## Test plan
- Single write then read, port 0: write blen=3 at addr 0x010 with data A0..A3 gives 4 acks at 0x010..0x013. Reading the same gives rvalid at T+1..T+4 with A0..A3.
- Simultaneous requests after reset: both `req` high; port 0 granted first (blen=1, 2 beats). Port 1 starts 2 cycles after port 0's last beat. The next tie goes to port 0 again only after port 1 has been served.
- Address wrap: ADDR_WIDTH=10, write blen=3 at 0x3FE gives `ram_addr` 0x3FE, 0x3FF, 0x000, 0x001.
- Stall: port 1 read blen=2, `req` dropped for 3 cycles after beat 1. No `ram_en`/ack/rvalid during the stall; resume completes beats 2-3 at the correct addresses. Port 0 `req` stays unacked throughout.
- Max burst: blen=15 gives exactly 16 beats, then IDLE.
- Reset mid-read-burst: assert `resetn` low right after a read beat. The next cycle shows `rvalid`=0, `ram_en`=0, IDLE, and after release the tie goes to port 0.
